// File: rtl/axis_packetizer_if.sv
// AXI4-Stream style beat channel shared by the packetizer's upstream and downstream sides.
// The slave side carries no last flag because packet boundaries are generated, not received.
interface axis_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/axis_packetizer.sv
// Stream packetizer: a 2-entry skid buffer that tags every PKT_BEATS-th accepted beat as last.
// Define AXIS_PACKETIZER_STATUS_EN to add the pkt_count and stall_flag status outputs.
module axis_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_BEATS  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  axis_packetizer_if.slave     s_axis,
  axis_packetizer_if.master    m_axis,
  output logic [CNT_WIDTH-1:0] beat_count
`ifdef AXIS_PACKETIZER_STATUS_EN
  ,
  output logic [31:0]          pkt_count,
  output logic                 stall_flag
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_BEATS - 1);

  state_t                state, state_next;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] out_data, skid_data;
  logic                  out_last, skid_last;
  logic                  accept, emit, in_last;
  logic                  load_out, load_skid, out_from_skid;

  assign accept  = s_axis.valid && ready_q;
  assign emit    = m_axis.valid && m_axis.ready;
  assign in_last = (beat_count == LAST_IDX);

  assign s_axis.ready = ready_q;
  assign m_axis.valid = (state != EMPTY);
  assign m_axis.data  = out_data;
  assign m_axis.last  = out_last;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_next = ONE;
        load_out   = 1'b1;
      end
      ONE: case ({accept, emit})
        2'b10: begin
          state_next = FULL;
          load_skid  = 1'b1;
        end
        2'b01:   state_next = EMPTY;
        2'b11:   load_out   = 1'b1;
        default: state_next = ONE;
      endcase
      FULL: if (emit) begin
        state_next    = ONE;
        out_from_skid = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state      <= EMPTY;
      ready_q    <= 1'b0;
      beat_count <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      state   <= state_next;
      // Ready comes from the next state so it never follows m_axis.ready combinationally.
      ready_q <= (state_next != FULL);
      if (accept) beat_count <= in_last ? '0 : beat_count + 1'b1;
      if (load_out) begin
        out_data <= s_axis.data;
        out_last <= in_last;
      end else if (out_from_skid) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end
    end
  end

  // NOTE: skid storage is not reset; the state register alone says whether it holds a beat.
  always_ff @(posedge axi_clk) begin
    if (load_skid) begin
      skid_data <= s_axis.data;
      skid_last <= in_last;
    end
  end

`ifdef AXIS_PACKETIZER_STATUS_EN
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      pkt_count  <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (emit && out_last) pkt_count <= pkt_count + 32'd1;
      if (m_axis.valid && !m_axis.ready) stall_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Scoreboard bench for axis_packetizer: a PKT_BEATS=4 instance and a PKT_BEATS=1 instance.
// Status outputs are checked only when AXIS_PACKETIZER_STATUS_EN is defined.
module tb_axis_packetizer;
  localparam int DW = 32;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_packetizer_if #(.DATA_WIDTH(DW)) s4 ();
  axis_packetizer_if #(.DATA_WIDTH(DW)) m4 ();
  axis_packetizer_if #(.DATA_WIDTH(DW)) s1 ();
  axis_packetizer_if #(.DATA_WIDTH(DW)) m1 ();
  logic [15:0] bc4, bc1;
`ifdef AXIS_PACKETIZER_STATUS_EN
  logic [31:0] pc4, pc1;
  logic        sf4, sf1;
`endif

  axis_packetizer #(.DATA_WIDTH(DW), .PKT_BEATS(4), .CNT_WIDTH(16)) dut4 (
    .axi_clk(clk), .axi_rst(rst), .s_axis(s4), .m_axis(m4), .beat_count(bc4)
`ifdef AXIS_PACKETIZER_STATUS_EN
    , .pkt_count(pc4), .stall_flag(sf4)
`endif
  );

  axis_packetizer #(.DATA_WIDTH(DW), .PKT_BEATS(1), .CNT_WIDTH(16)) dut1 (
    .axi_clk(clk), .axi_rst(rst), .s_axis(s1), .m_axis(m1), .beat_count(bc1)
`ifdef AXIS_PACKETIZER_STATUS_EN
    , .pkt_count(pc1), .stall_flag(sf1)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  beat_t q4[$];
  beat_t q1[$];
  int    idx4   = 0;
  int    emits4 = 0;
  int    emits1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat into dut4 until accepted; expected last comes from the bench's own beat index.
  task automatic send4(input logic [DW-1:0] d);
    beat_t b;
    s4.valid = 1'b1;
    s4.data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s4.ready) begin
        b.last = (idx4 == 3);
        b.data = d;
        q4.push_back(b);
        idx4 = (idx4 + 1) % 4;
        @(posedge clk) #1;
        return;
      end
      @(posedge clk) #1;
    end
    errors++;
    $display("FAIL send4 timeout: beat %0h never accepted", d);
  endtask

  task automatic send1(input logic [DW-1:0] d);
    beat_t b;
    s1.valid = 1'b1;
    s1.data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s1.ready) begin
        b.last = 1'b1;
        b.data = d;
        q1.push_back(b);
        @(posedge clk) #1;
        return;
      end
      @(posedge clk) #1;
    end
    errors++;
    $display("FAIL send1 timeout: beat %0h never accepted", d);
  endtask

  // Monitor: pops on each pending emit and checks that stalled outputs hold.
  logic  prev_stall4 = 1'b0;
  beat_t prev4, exp4, exp1;
  always @(negedge clk) begin
    if (prev_stall4) begin
      check("hold_valid", 64'(m4.valid), 64'd1);
      check("hold_beat", 64'({m4.last, m4.data}), 64'(prev4));
    end
    if (m4.valid && m4.ready) begin
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dut4_unexpected: got %0h expected none", m4.data);
      end else begin
        exp4 = q4.pop_front();
        check("dut4_beat", 64'({m4.last, m4.data}), 64'(exp4));
      end
      emits4++;
    end
    prev_stall4 = m4.valid && !m4.ready && !rst;
    prev4       = {m4.last, m4.data};
    if (m1.valid && m1.ready) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected: got %0h expected none", m1.data);
      end else begin
        exp1 = q1.pop_front();
        check("dut1_beat", 64'({m1.last, m1.data}), 64'(exp1));
      end
      emits1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s4.valid = 1'b0; s4.data = '0; s4.last = 1'b0; m4.ready = 1'b0;
    s1.valid = 1'b0; s1.data = '0; s1.last = 1'b0; m1.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(s4.ready), 64'd0);
    check("rst_m_valid", 64'(m4.valid), 64'd0);
    check("rst_m_last", 64'(m4.last), 64'd0);
    check("rst_m_data", 64'(m4.data), 64'd0);
    check("rst_beat_count", 64'(bc4), 64'd0);
    rst = 1'b0;
    @(posedge clk) #1;
    check("ready_after_rst", 64'(s4.ready), 64'd1);
`ifdef AXIS_PACKETIZER_STATUS_EN
    check("stall_init", 64'(sf4), 64'd0);
    check("pkt_count_init", 64'(pc4), 64'd0);
`endif

    // Streaming: 8 beats at full rate, last on 0x03 and 0x07.
    m4.ready = 1'b1;
    emits4   = 0;
    for (int i = 0; i < 8; i++) begin
      send4(DW'(i));
      if (i == 0) check("latency_valid", 64'(m4.valid), 64'd1);
    end
    s4.valid = 1'b0;
    @(posedge clk) #1;
    check("stream_emits", 64'(emits4), 64'd8);
    check("stream_idle", 64'(m4.valid), 64'd0);
    check("stream_count", 64'(bc4), 64'd0);

    // Backpressure: downstream stalled while 0xA0..0xA2 are offered.
    m4.ready = 1'b0;
    fork
      begin
        send4(32'hA0); send4(32'hA1); send4(32'hA2);
        s4.valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_ready_low", 64'(s4.ready), 64'd0);
        check("bp_valid", 64'(m4.valid), 64'd1);
        check("bp_head", 64'(m4.data), 64'hA0);
        repeat (3) @(posedge clk);
        #1;
        m4.ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 64'(q4.size()), 64'd0);
    check("bp_count", 64'(bc4), 64'd3);
`ifdef AXIS_PACKETIZER_STATUS_EN
    check("stall_set", 64'(sf4), 64'd1);
`endif

    // Simultaneous accept/emit with downstream ready toggling.
    fork
      begin
        for (int i = 0; i < 10; i++) send4(DW'(32'h10 + i));
        s4.valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          m4.ready = ~m4.ready;
          @(posedge clk) #1;
        end
        m4.ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("toggle_drained", 64'(q4.size()), 64'd0);
    check("toggle_count", 64'(bc4), 64'd1);

    // Reset mid-packet: finish the open packet, buffer 2 beats, then reset.
    m4.ready = 1'b1;
    send4(32'h2D); send4(32'h2E); send4(32'h2F);
    s4.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_count", 64'(bc4), 64'd0);
    m4.ready = 1'b0;
    send4(32'h30); send4(32'h31);
    s4.valid = 1'b0;
`ifdef AXIS_PACKETIZER_STATUS_EN
    check("stall_persist", 64'(sf4), 64'd1);
`endif
    rst = 1'b1;
    @(posedge clk) #1;
    check("mid_rst_valid", 64'(m4.valid), 64'd0);
    check("mid_rst_count", 64'(bc4), 64'd0);
    check("mid_rst_ready", 64'(s4.ready), 64'd0);
`ifdef AXIS_PACKETIZER_STATUS_EN
    check("stall_cleared", 64'(sf4), 64'd0);
`endif
    q4.delete();
    idx4 = 0;
    rst  = 1'b0;
    @(posedge clk) #1;
    check("ready_after_mid_rst", 64'(s4.ready), 64'd1);
    m4.ready = 1'b1;
    for (int i = 0; i < 4; i++) send4(DW'(32'h40 + i));
    s4.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_drained", 64'(q4.size()), 64'd0);
    check("post_rst_count", 64'(bc4), 64'd0);

    // PKT_BEATS=1: every beat is last, count stays 0.
    emits1 = 0;
    send1(32'h50); send1(32'h51); send1(32'h52);
    s1.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("single_emits", 64'(emits1), 64'd3);
    check("single_drained", 64'(q1.size()), 64'd0);
    check("single_count", 64'(bc1), 64'd0);
`ifdef AXIS_PACKETIZER_STATUS_EN
    check("single_pkt_count", 64'(pc1), 64'd3);
    check("single_no_stall", 64'(sf1), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter PKT_BEATS, default 1024, giving the number of beats per packet (legal range 1..65535).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, giving the beat-counter width (2^CNT_WIDTH >= PKT_BEATS).
REQ-004 SHALL have port axi_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port axi_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port s_axis_valid, input, 1 bit: upstream (pixel-processing stage) beat valid.
REQ-007 SHALL have port s_axis_ready, output, 1 bit: block can take a beat; registered.
REQ-008 SHALL have port s_axis_data, input, DATA_WIDTH bits: upstream beat payload.
REQ-009 SHALL have port m_axis_valid, output, 1 bit: downstream (DMA S2MM) beat valid.
REQ-010 SHALL have port m_axis_ready, input, 1 bit: downstream accepts the beat.
REQ-011 SHALL have port m_axis_data, output, DATA_WIDTH bits: downstream beat payload.
REQ-012 SHALL have port m_axis_last, output, 1 bit: marks the final beat of a packet.
REQ-013 SHALL have port beat_count, output, CNT_WIDTH bits: number of beats accepted so far in the current packet.

Function
REQ-014 SHALL define an accept as s_axis_valid && s_axis_ready, and an emit as m_axis_valid && m_axis_ready, both sampled at the rising edge.
REQ-015 SHALL hold data in a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-016 SHALL make these state transitions: EMPTY->ONE on accept; ONE->FULL on accept without emit; ONE->EMPTY on emit without accept; ONE->ONE on accept with emit; FULL->ONE on emit.
REQ-017 SHALL drive s_axis_ready high in EMPTY and ONE and low in FULL, registered from the next state, so ready never depends combinationally on m_axis_ready.
REQ-018 SHALL make the first accepted beat visible on m_axis_valid/m_axis_data on the cycle after the accept (latency 1).
REQ-019 SHALL sustain 1 beat per cycle while m_axis_ready is held high.
REQ-020 SHALL keep m_axis_data, m_axis_last and m_axis_valid stable while m_axis_valid=1 and m_axis_ready=0.
REQ-021 SHALL never drop m_axis_valid without an emit.
REQ-022 SHALL deliver beats in acceptance order with no loss and no duplication.
REQ-023 SHALL increment beat_count on each accept, and on the accept where beat_count==PKT_BEATS-1 tag that beat last=1 and wrap beat_count to 0.
REQ-024 SHALL store the tag alongside the data and output it on m_axis_last with that beat.
REQ-025 SHALL tag every beat last=1 when PKT_BEATS=1, with beat_count remaining 0.
REQ-026 SHALL ignore s_axis_valid while s_axis_ready=0 and leave s_axis_data unsampled.
REQ-027 SHALL leave m_axis_data unchanged when empty, while holding m_axis_valid=0.

Reset
REQ-028 SHALL, on the rising edge with axi_rst=1, set state=EMPTY, m_axis_valid=0, m_axis_last=0, s_axis_ready=0, beat_count=0 and m_axis_data=0.
REQ-029 SHALL discard any buffered or partial-packet beats when reset is asserted mid-packet; the next accepted beat starts a new packet.
REQ-030 SHALL raise s_axis_ready on the first rising edge with axi_rst=0.

Configuration
REQ-031 SHALL, when macro AXIS_PACKETIZER_STATUS_EN is defined, add output pkt_count (32 bits), which increments on each emit with m_axis_last=1, resets to 0 and wraps at 2^32.
REQ-032 SHALL, when AXIS_PACKETIZER_STATUS_EN is defined, add output stall_flag (1 bit), which sets on any cycle with m_axis_valid=1 and m_axis_ready=0 and clears only on reset.
REQ-033 SHALL, when AXIS_PACKETIZER_STATUS_EN is undefined, omit both ports and their logic; all other behaviour is identical.

Verification
REQ-034 SHALL verify streaming: PKT_BEATS=4, m_axis_ready=1, with 8 consecutive beats 0x00..0x07 driven -> outputs 0x00..0x07 one cycle later at 1 beat/cycle, and last=1 on 0x03 and 0x07.
REQ-035 SHALL verify backpressure: m_axis_ready=0 for 5 cycles while driving beats 0xA0, 0xA1, 0xA2 -> s_axis_ready=0 after 2 accepts, output holds 0xA0, and after ready=1 the outputs are 0xA0, 0xA1, 0xA2 in order.
REQ-036 SHALL verify simultaneous accept/emit in ONE for 10 cycles with m_axis_ready toggling 1/0 -> no loss or duplicates, with last on every 4th beat.
REQ-037 SHALL verify reset mid-packet: after 2 beats of a PKT_BEATS=4 packet, with axi_rst=1 for 1 cycle -> m_axis_valid=0 and beat_count=0, and the next 4 beats yield last on the 4th.
REQ-038 SHALL verify PKT_BEATS=1: 3 beats -> last=1 on all 3, and pkt_count=3 with AXIS_PACKETIZER_STATUS_EN defined.
REQ-039 SHALL verify stall_flag: with AXIS_PACKETIZER_STATUS_EN defined, one cycle of valid=1 and ready=0 -> stall_flag=1 persisting until axi_rst.
